// File: rtl/bagman_input_ctrl.sv
// bagman_input_ctrl: input conditioning between hps_io and the bagman core.
//   Turns PS/2 key events into held key states, ORs them with both joysticks,
//   generates a fixed-length, lockout-protected coin pulse and registers the
//   active-low player bytes in either the Bagman or Super Bagman layout.
//
// Ports:
//   clk_sys     in   system clock (12 MHz)
//   reset       in   synchronous, active-high
//   ps2_key     in   [10] toggle strobe, [9] pressed, [8:0] extended scan code
//   joystick_0  in   hps_io joystick 0, active-high
//   joystick_1  in   hps_io joystick 1, active-high
//   mod_sbag    in   1 = Super Bagman layout (start bits also driven by fire2)
//   joy_p1      out  player 1 byte, active-low
//   joy_p2      out  player 2 byte, active-low
//   coin_busy   out  high while the coin pulse or its lockout gap is running
//
// Build option: define BAGMAN_INPUT_SOCD_EN to cancel opposite directions
// (up+down, left+right) per player before the output register.
module bagman_input_ctrl #(
    parameter int TICK_DIV    = 12000,
    parameter int COIN_MS     = 50,
    parameter int COIN_GAP_MS = 100
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        mod_sbag,
    output logic [7:0]  joy_p1,
    output logic [7:0]  joy_p2,
    output logic        coin_busy
);
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX = (COIN_MS > COIN_GAP_MS) ? COIN_MS : COIN_GAP_MS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(COIN_MS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(COIN_GAP_MS - 1);

    typedef struct packed {
        logic up, down, left, right, fire1, fire2, start;
    } pad_t;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

    // ---------------- PS/2 key state ----------------
    pad_t k1, k2;
    logic k_coin1, k_coin2, old_strobe;
    logic key_ev, pressed;

    assign key_ev  = ps2_key[10] != old_strobe;
    assign pressed = ps2_key[9];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            k1         <= '0;
            k2         <= '0;
            k_coin1    <= 1'b0;
            k_coin2    <= 1'b0;
            // Track the current strobe level so reset release is not an event.
            old_strobe <= ps2_key[10];
        end else begin
            old_strobe <= ps2_key[10];
            if (key_ev) begin
                casez (ps2_key[8:0])
                    9'b?_0111_0101: k1.up    <= pressed;  // X75
                    9'b?_0111_0010: k1.down  <= pressed;  // X72
                    9'b?_0110_1011: k1.left  <= pressed;  // X6B
                    9'b?_0111_0100: k1.right <= pressed;  // X74
                    9'h029:         k1.fire1 <= pressed;
                    9'h014:         k1.fire2 <= pressed;
                    9'h005, 9'h016: k1.start <= pressed;
                    9'h006, 9'h01E: k2.start <= pressed;
                    9'h02E:         k_coin1  <= pressed;
                    9'h036:         k_coin2  <= pressed;
                    9'h02D:         k2.up    <= pressed;
                    9'h02B:         k2.down  <= pressed;
                    9'h023:         k2.left  <= pressed;
                    9'h034:         k2.right <= pressed;
                    9'h01C:         k2.fire1 <= pressed;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- merge with joysticks ----------------
    logic [15:0] joy;
    logic        unused_joy;
    pad_t        p1_raw, p2_raw, p1, p2;

    assign joy        = joystick_0 | joystick_1;
    assign unused_joy = ^{joy[15:9], k2.fire2};

    function automatic pad_t socd(input pad_t p);
        pad_t r;
        r = p;
`ifdef BAGMAN_INPUT_SOCD_EN
        if (p.up && p.down) begin
            r.up   = 1'b0;
            r.down = 1'b0;
        end
        if (p.left && p.right) begin
            r.left  = 1'b0;
            r.right = 1'b0;
        end
`endif
        return r;
    endfunction

    always_comb begin
        p1_raw.up    = k1.up    | joy[3];
        p1_raw.down  = k1.down  | joy[2];
        p1_raw.left  = k1.left  | joy[1];
        p1_raw.right = k1.right | joy[0];
        p1_raw.fire1 = k1.fire1 | joy[4];
        p1_raw.fire2 = k1.fire2 | joy[5];
        p1_raw.start = k1.start | joy[6];
        p2_raw.up    = k2.up    | joy[3];
        p2_raw.down  = k2.down  | joy[2];
        p2_raw.left  = k2.left  | joy[1];
        p2_raw.right = k2.right | joy[0];
        p2_raw.fire1 = k2.fire1 | joy[4];
        p2_raw.fire2 = joy[5];              // no keyboard binding for P2 fire2
        p2_raw.start = k2.start | joy[7];
        p1 = socd(p1_raw);
        p2 = socd(p2_raw);
    end

    // ---------------- coin pulse FSM ----------------
    coin_state_t state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [TW-1:0] ticks, ticks_n;
    logic coin_req, coin_req_q;

    assign coin_req = k_coin1 | k_coin2 | joy[8];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            ticks      <= '0;
            coin_req_q <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            ticks      <= ticks_n;
            coin_req_q <= coin_req;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        ticks_n = ticks;
        unique case (state)
            IDLE: begin
                // Only a fresh rising edge starts a pulse; edges seen while
                // busy are dropped, and coin_req_q keeps tracking so a level
                // held through the gap cannot retrigger.
                if (coin_req && !coin_req_q) begin
                    state_n = PULSE;
                    presc_n = '0;
                    ticks_n = '0;
                end
            end
            PULSE, GAP: begin
                if (presc == PRE_LAST) begin
                    presc_n = '0;
                    if (ticks == ((state == PULSE) ? PULSE_LAST : GAP_LAST)) begin
                        ticks_n = '0;
                        state_n = (state == PULSE) ? GAP : IDLE;
                    end else begin
                        ticks_n = ticks + 1'b1;
                    end
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- output register ----------------
    logic s1, s2;

    assign s1 = mod_sbag ? (p1.start | p1.fire2) : p1.start;
    assign s2 = mod_sbag ? (p2.start | p2.fire2) : p2.start;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joy_p1    <= 8'hFF;
            joy_p2    <= 8'hFF;
            coin_busy <= 1'b0;
        end else begin
            joy_p1    <= ~{p1.fire1, p1.down, p1.up, p1.right, p1.left, s1, 1'b0,
                           state == PULSE};
            joy_p2    <= ~{p2.fire1, p2.down, p2.up, p2.right, p2.left, s2, 1'b0,
                           1'b0};
            // Registered alongside the bytes so it lines up with joy_p1[0].
            coin_busy <= state != IDLE;
        end
    end
endmodule

// File: tb/tb_bagman_input_ctrl.sv
module tb_bagman_input_ctrl;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic        mod_sbag;
    logic [7:0]  joy_p1, joy_p2;
    logic        coin_busy;

    int checks   = 0;
    int failures = 0;

    bagman_input_ctrl #(.TICK_DIV(4), .COIN_MS(3), .COIN_GAP_MS(2)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .mod_sbag(mod_sbag),
        .joy_p1(joy_p1), .joy_p2(joy_p2), .coin_busy(coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles with joy_p1[0] low and with coin_busy high over n cycles.
    task automatic watch(input int n, output int lows, output int busys, output int first_low);
        lows = 0; busys = 0; first_low = -1;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (!joy_p1[0]) begin
                if (first_low < 0) first_low = i;
                lows++;
            end
            if (coin_busy) busys++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_ud, exp_lr;
    int lows, busys, first;

    initial begin
        reset = 1'b1; mod_sbag = 1'b0;
        joystick_0 = '0; joystick_1 = '0;
        ps2_key = {1'b1, 1'b1, 9'h175};
        step(3);
        chk("reset_p1", joy_p1, 8'hFF);
        chk("reset_p2", joy_p2, 8'hFF);
        chk("reset_busy", coin_busy, 1'b0);
        reset = 1'b0;
        step(3);
        chk("no_event_after_reset", joy_p1, 8'hFF);

        // Key events (strobe currently 1)
        ps2_key = {1'b0, 1'b1, 9'h175};
        step(1); chk("key_up_lat1", joy_p1, 8'hFF);
        step(1); chk("key_up_press", joy_p1, 8'hDF);
        ps2_key = {1'b1, 1'b0, 9'h175};
        step(2); chk("key_up_release", joy_p1, 8'hFF);
        ps2_key = {1'b0, 1'b1, 9'h02D};
        step(2); chk("key_p2_up", joy_p2, 8'hDF);
        chk("key_p2_up_p1", joy_p1, 8'hFF);
        ps2_key = {1'b1, 1'b0, 9'h02D};
        step(2); chk("key_p2_up_rel", joy_p2, 8'hFF);
        ps2_key = {1'b0, 1'b1, 9'h06B};
        step(2); chk("key_left_nonext", joy_p1, 8'hF7);
        ps2_key = {1'b1, 1'b1, 9'h1AA};
        step(2); chk("key_unmatched", joy_p1, 8'hF7);
        ps2_key = {1'b0, 1'b0, 9'h16B};
        step(2); chk("key_left_ext_rel", joy_p1, 8'hFF);
        ps2_key = {1'b1, 1'b1, 9'h016};
        step(2); chk("key_start1", joy_p1, 8'hFB);
        ps2_key = {1'b0, 1'b0, 9'h016};
        step(2); chk("key_start1_rel", joy_p1, 8'hFF);
        ps2_key = {1'b0, 1'b1, 9'h016};  // no strobe toggle: not an event
        step(2); chk("key_no_toggle", joy_p1, 8'hFF);

        // One-cycle coin pulse from joystick_1
        joystick_1[8] = 1'b1;
        step(1);
        joystick_1[8] = 1'b0;
        chk("coin_lat1", joy_p1, 8'hFF);
        watch(40, lows, busys, first);
        chk("coin_first_low", first, 0);
        chk("coin_pulse_len", lows, 12);
        chk("coin_busy_len", busys, 20);
        chk("coin_busy_end", coin_busy, 1'b0);

        // Held level: exactly one pulse
        joystick_0[8] = 1'b1;
        watch(100, lows, busys, first);
        chk("coin_held_one_pulse", lows, 12);
        joystick_0[8] = 1'b0;
        step(2);
        // New edge, then a second edge inside GAP
        joystick_0[8] = 1'b1;
        watch(16, lows, busys, first);
        chk("coin_edge2_pulse", lows, 12);
        joystick_0[8] = 1'b0;
        step(1);
        chk("coin_in_gap", coin_busy, 1'b1);
        joystick_0[8] = 1'b1;
        watch(20, lows, busys, first);
        chk("coin_gap_edge_ignored", lows, 0);
        joystick_0[8] = 1'b0;
        step(2);
        joystick_0[8] = 1'b1;
        watch(20, lows, busys, first);
        chk("coin_after_gap", lows, 12);
        joystick_0[8] = 1'b0;
        step(2);

        // Keyboard coin: 3-cycle latency
        ps2_key = {1'b1, 1'b1, 9'h02E};
        step(2); chk("kcoin_lat2", joy_p1, 8'hFF);
        step(1); chk("kcoin_low", joy_p1, 8'hFE);
        ps2_key = {1'b0, 1'b0, 9'h02E};
        step(30);
        chk("kcoin_idle", coin_busy, 1'b0);

        // Super Bagman start mapping
        mod_sbag = 1'b1; joystick_0 = 16'h0020;
        step(1);
        chk("sbag_p1", joy_p1, 8'hFB);
        chk("sbag_p2", joy_p2, 8'hFB);
        mod_sbag = 1'b0;
        step(1);
        chk("bag_p1", joy_p1, 8'hFF);
        chk("bag_p2", joy_p2, 8'hFF);

        // Joystick merge
        joystick_0 = '0; joystick_1 = 16'h0010;
        step(1);
        chk("joy_fire1_p1", joy_p1, 8'h7F);
        chk("joy_fire1_p2", joy_p2, 8'h7F);
        joystick_1 = 16'h0080; joystick_0 = 16'h0040;
        step(1);
        chk("joy_start1", joy_p1, 8'hFB);
        chk("joy_start2", joy_p2, 8'hFB);

        // Opposite directions
`ifdef BAGMAN_INPUT_SOCD_EN
        exp_ud = 8'hFF; exp_lr = 8'hFF;
`else
        exp_ud = 8'h9F; exp_lr = 8'hE7;
`endif
        joystick_1 = '0; joystick_0 = 16'h000C;
        step(1);
        chk("socd_ud_p1", joy_p1, exp_ud);
        chk("socd_ud_p2", joy_p2, exp_ud);
        joystick_0 = 16'h0003;
        step(1);
        chk("socd_lr_p1", joy_p1, exp_lr);
        joystick_0 = '0;
        step(1);
        chk("final_idle", joy_p1, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
